// File: rtl/unflatten_buffer_pkg.sv
// Shared CNN definitions for the unflatten buffer.
// Holds the default pixel width and feature-map size, plus the buffer FSM state type.
package unflatten_buffer_pkg;

    localparam int unsigned DefDataWidth     = 8;
    localparam int unsigned DefPoolOfmapSize = 2;
    localparam int unsigned DefPoolPixelCnt  = DefPoolOfmapSize * DefPoolOfmapSize;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull
    } buf_state_e;

endpackage

// File: rtl/unflatten_buffer_raster_counter.sv
// Row-major raster position generator for a square SIZE x SIZE map.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous return to position (0,0); wins over enable
//   enable       : advance one position
//   row, col     : current write position
//   last         : current position is the final pixel of the frame
module raster_counter
    import unflatten_buffer_pkg::*;
#(
    parameter int unsigned SIZE  = DefPoolOfmapSize,
    parameter int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(SIZE - 1);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             col_wrap;

    assign col_wrap = (col_q == MaxIdx);
    assign last     = col_wrap && (row_q == MaxIdx);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (enable) begin
            if (last) begin
                row_d = '0;
                col_d = '0;
            end else if (col_wrap) begin
                row_d = row_q + IDX_W'(1);
                col_d = '0;
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/unflatten_buffer.sv
// Reassembles a row-major serial pixel stream into a square 2D feature map.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   clear                 : synchronous discard of the partial or held frame
//   in_pixel/valid/ready  : serial pixel input handshake
//   feature_out           : assembled map, [row][col]; qualified only by out_valid
//   out_valid/out_ready   : frame output handshake
//   fill_count            : pixels held in the current frame
module unflatten_buffer
    import unflatten_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DefDataWidth,
    parameter int unsigned POOL_OFMAP_SIZE  = DefPoolOfmapSize,
    parameter int unsigned POOL_PIXEL_COUNT = POOL_OFMAP_SIZE * POOL_OFMAP_SIZE,
    localparam int unsigned IdxW = (POOL_OFMAP_SIZE > 1) ? $clog2(POOL_OFMAP_SIZE) : 1,
    localparam int unsigned CntW = $clog2(POOL_PIXEL_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1][DATA_WIDTH-1:0] feature_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CntW-1:0]       fill_count
);

    buf_state_e      state_q, state_d;
    logic [CntW-1:0] fill_q, fill_d;
    logic [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1][DATA_WIDTH-1:0] feature_q;

    logic [IdxW-1:0] row, col;
    logic            last;
    logic            accept;
    logic            out_xfer;

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q == StFull);
    // clear drops any pixel or frame transfer presented in the same cycle
    assign accept    = in_valid && in_ready && !clear;
    assign out_xfer  = out_valid && out_ready && !clear;

    raster_counter #(
        .SIZE  (POOL_OFMAP_SIZE),
        .IDX_W (IdxW)
    ) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .enable  (accept),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (clear) begin
            state_d = StIdle;
            fill_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        // a one-pixel frame completes on its first pixel
                        state_d = last ? StFull : StFill;
                        fill_d  = fill_q + CntW'(1);
                    end
                end
                StFill: begin
                    if (accept) begin
                        if (last) state_d = StFull;
                        fill_d = fill_q + CntW'(1);
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        state_d = StIdle;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    fill_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Unwritten cells deliberately keep stale data from earlier frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            feature_q <= '0;
        end else if (accept) begin
            feature_q[row][col] <= in_pixel;
        end
    end

    assign feature_out = feature_q;
    assign fill_count  = fill_q;

endmodule

// File: tb/tb_unflatten_buffer.sv
module tb_unflatten_buffer;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic [0:1][0:1][7:0] feature_out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill_count;

    unflatten_buffer #(
        .DATA_WIDTH       (8),
        .POOL_OFMAP_SIZE  (2),
        .POOL_PIXEL_COUNT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .in_pixel    (in_pixel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .feature_out (feature_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_count  (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a 4-entry frame memory filled in arrival order, a held count
    // and a "frame complete" flag.
    logic [7:0] m_mem [4];
    int         m_n      = 0;
    bit         m_full   = 1'b0;
    int         m_frames = 0;

    function automatic logic [31:0] m_pack();
        return {m_mem[0], m_mem[1], m_mem[2], m_mem[3]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        m_n    = 0;
        m_full = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, compare outputs before the edge, advance model.
    task automatic cycle(input logic v, input logic [7:0] p, input logic ordy, input logic clr);
        in_valid  = v;
        in_pixel  = p;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!m_full));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        chk("fill_count", 64'(fill_count), m_full ? 64'd4 : 64'(m_n));
        chk("feature_out", 64'(feature_out), 64'(m_pack()));
        if (clr) begin
            m_n    = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (ordy) begin
                m_full = 1'b0;
                m_n    = 0;
                m_frames++;
            end
        end else if (v) begin
            m_mem[m_n] = p;
            m_n++;
            if (m_n == 4) m_full = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int budget;
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        out_ready = 1'b0;
        m_reset();
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fill_count", 64'(fill_count), 64'd0);
        chk("rst_feature", 64'(feature_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back frame 1,2,3,4
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        chk("frame1_out_valid", 64'(out_valid), 64'd1);
        chk("frame1_feature", 64'(feature_out), 64'h01020304);
        chk("frame1_fill", 64'(fill_count), 64'd4);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: frame held while pixel 9 waits
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'd9, 1'b0, 1'b0);
        chk("hold_feature", 64'(feature_out), 64'h10111213);
        cycle(1'b1, 8'd9, 1'b1, 1'b0);
        chk("bubble_in_ready", 64'(in_ready), 64'd1);
        cycle(1'b1, 8'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("after_bp_feature", 64'(feature_out), 64'h09202122);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Clear mid-frame drops partial frame and the clear-cycle pixel
        cycle(1'b1, 8'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'd2, 1'b1, 1'b0);
        cycle(1'b1, 8'd7, 1'b1, 1'b1);
        chk("clear_fill", 64'(fill_count), 64'd0);
        for (int i = 5; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("clear_frame", 64'(feature_out), 64'h05060708);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset after 3 pixels
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_fill", 64'(fill_count), 64'd0);
        chk("arst_feature", 64'(feature_out), 64'd0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("arst_frame", 64'(feature_out), 64'h40414243);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random gaps over 100 frames
        start  = m_frames;
        budget = 0;
        while (m_frames < start + 100 && budget < 20000) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            budget++;
        end
        chk("random_frames", 64'(m_frames - start), 64'd100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unflatten_buffer.md
UNFLATTEN_BUFFER -- requirements
Module: unflatten_buffer

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default from cnn_defs.svh, meaning pixel bit width.
REQ-002 The block SHALL take parameter POOL_OFMAP_SIZE, default from cnn_defs.svh, meaning the side length of the square feature map.
REQ-003 The block SHALL take parameter POOL_PIXEL_COUNT, default POOL_OFMAP_SIZE*POOL_OFMAP_SIZE, meaning pixels per frame.
REQ-004 clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 clear, input, 1: synchronous discard of any partial frame.
REQ-007 in_pixel, input, DATA_WIDTH: serial pixel, row-major order.
REQ-008 in_valid, input, 1; in_ready, output, 1: input handshake; a pixel transfers when both are high at a clock edge.
REQ-009 feature_out, output, [0:POOL_OFMAP_SIZE-1][0:POOL_OFMAP_SIZE-1] of DATA_WIDTH: assembled 2D map.
REQ-010 out_valid, output, 1; out_ready, input, 1: output handshake; a frame transfers when both are high at a clock edge.
REQ-011 fill_count, output, $clog2(POOL_PIXEL_COUNT+1): pixels held in the current frame.

Function
REQ-012 Serial pixel k SHALL be written to feature_out[k / POOL_OFMAP_SIZE][k % POOL_OFMAP_SIZE], the exact inverse of the row-major flatten.
REQ-013 The FSM SHALL have three states:
- IDLE: no pixels held.
- FILL: 1..POOL_PIXEL_COUNT-1 pixels held.
- FULL: frame complete.
REQ-014 Transitions SHALL be:
- IDLE -> FILL on an accepted pixel when POOL_PIXEL_COUNT>1; IDLE -> FULL when POOL_PIXEL_COUNT==1.
- FILL -> FULL on acceptance of pixel POOL_PIXEL_COUNT-1.
- FULL -> IDLE on an output transfer.
REQ-015 in_ready SHALL be 1 in IDLE and FILL, and 0 in FULL.
REQ-016 out_valid SHALL be 1 exactly in FULL.
REQ-017 Latency: out_valid SHALL rise in the cycle after the last pixel is accepted.
REQ-018 While out_valid=1 and out_ready=0, feature_out and out_valid SHALL hold stable.
REQ-019 After an output transfer, in_ready SHALL return to 1 on the next cycle; this one-cycle bubble is the only one.
REQ-020 Row and column indices SHALL wrap: column resets to 0 after POOL_OFMAP_SIZE-1 and row increments; both reset to 0 on frame completion.
REQ-021 fill_count SHALL increment per accepted pixel, read POOL_PIXEL_COUNT in FULL, and read 0 in IDLE.
REQ-022 clear SHALL take priority over all other events: the next state is IDLE, indices and fill_count go to 0, and any pixel presented in that cycle is dropped. In FULL, clear also drops the held frame.
REQ-023 feature_out cells not yet written in the current frame SHALL keep their previous values; only out_valid qualifies the data.
REQ-024 in_valid with in_ready=0 SHALL have no effect, and no pixel SHALL be lost.

Reset
REQ-025 reset_n=0 SHALL asynchronously force:
- state IDLE, row/column indices and fill_count 0;
- out_valid 0, in_ready 1 after the reset is released, every feature_out cell 0.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is pixel 0.

Structure
REQ-027 DATA_WIDTH, POOL_OFMAP_SIZE and POOL_PIXEL_COUNT, plus the FSM state typedef, SHALL live in the shared cnn_defs.svh package.
REQ-028 One sub-module, raster_counter, SHALL generate row, column and last-pixel flag with enable and clear; storage and the FSM stay in unflatten_buffer.

Verification
REQ-029 With POOL_OFMAP_SIZE=2, stream 1,2,3,4 back-to-back with out_ready=1 -> out_valid in the cycle after 4 is accepted; feature_out=[[1,2],[3,4]]; fill_count=4.
REQ-030 Hold out_ready=0 for 5 cycles with in_valid=1 and pixel 9 presented -> in_ready=0, feature_out stable, 9 not consumed; raise out_ready -> 9 becomes pixel 0 of the next frame after a one-cycle bubble.
REQ-031 Send 2 pixels, pulse clear with in_valid=1 and pixel 7, then send 5,6,7,8 -> output [[5,6],[7,8]]; 7 from the clear cycle is dropped.
REQ-032 Assert reset_n=0 asynchronously after 3 pixels -> out_valid=0, fill_count=0, feature_out all 0 immediately; the following 4 pixels form a clean frame.
REQ-033 Random in_valid/out_ready gaps over 100 frames -> every output frame equals the row-major reshape of its 4 inputs; no pixel lost or duplicated.
